// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word RAM with byte-lane writes, one access at a time.
// Latency: stores complete 1 cycle after acceptance, loads READ_LATENCY cycles after acceptance.
// Backpressure: data_mem_busy high while an access runs; requests arriving then are dropped.
// Optional feature macro: DATA_MEM_MMIO_EN (top 256 bytes become a single MMIO register).
module data_mem_ctrl #(
    parameter int DMEM_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_mem_req,
    input  logic [DMEM_WIDTH-1:0] data_mem_addr,
    input  logic [3:0]            data_mem_wmask,
    input  logic [31:0]           data_mem_write,
    output logic [31:0]           data_mem_read,
    output logic                  data_mem_valid,
    output logic                  data_mem_busy
`ifdef DATA_MEM_MMIO_EN
    ,
    output logic [31:0]           mmio_out,
    output logic                  mmio_we
`endif
);

    localparam int AW    = DMEM_WIDTH - 2;
    localparam int WORDS = 2 ** AW;
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           done;
    logic           ld_done;
    logic [31:0]    rd_word_q;
    logic [31:0]    load_src;
    logic [AW-1:0]  word_idx;
    logic           accept;
    logic           is_store;
    logic           ram_we;
    logic           addr_unused;

    logic [31:0]    mem [0:WORDS-1];

    // Byte offset bits never matter: every access is a full word slot.
    assign addr_unused = ^data_mem_addr[1:0];

    assign word_idx = data_mem_addr[DMEM_WIDTH-1:2];
    assign accept   = (state_q == IDLE) && data_mem_req;
    assign is_store = |data_mem_wmask;

`ifdef DATA_MEM_MMIO_EN
    logic in_win;
    // The whole top 256-byte window aliases onto one register.
    assign in_win   = &data_mem_addr[DMEM_WIDTH-1:8];
    assign ram_we   = accept && is_store && !in_win;
    assign load_src = in_win ? mmio_out : mem[word_idx];
`else
    assign ram_we   = accept && is_store;
    assign load_src = mem[word_idx];
`endif

    // Busy is simply "not idle", so an async reset drops it immediately.
    assign data_mem_busy = (state_q != IDLE);

    // State and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; done marks the cycle whose closing edge raises valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        ld_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_mem_req) begin
                    state_d = is_store ? STORE : LOAD;
                    cnt_d   = LAT_M1;
                end
            end
            STORE: begin
                state_d = IDLE;
                done    = 1'b1;
            end
            LOAD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    done    = 1'b1;
                    ld_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion pulse, load pipeline register and the held load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_mem_valid <= 1'b0;
            data_mem_read  <= 32'd0;
            rd_word_q      <= 32'd0;
        end else begin
            data_mem_valid <= done;
            if (accept && !is_store) begin
                rd_word_q <= load_src;
            end
            if (ld_done) begin
                data_mem_read <= rd_word_q;
            end
        end
    end

    // RAM write port: contents are not reset, only enabled lanes change.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_mem_wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= data_mem_write[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_MEM_MMIO_EN
    // MMIO register: lane-masked update with a one-cycle write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_out <= 32'd0;
            mmio_we  <= 1'b0;
        end else begin
            mmio_we <= accept && is_store && in_win;
            if (accept && is_store && in_win) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_mem_wmask[i]) begin
                        mmio_out[8*i +: 8] <= data_mem_write[8*i +: 8];
                    end
                end
            end
        end
    end
`endif

endmodule
